id_ex_reg: RTL and testbench

Decode-to-execute pipeline register for the 5-stage RISC-V core, capturing the main decoder's control outputs with the decode-stage operands for the execute stage. Integrates load-use hazard detection: it stalls fetch/decode and injects a bubble into execute. Honours a branch-resolution flush and a downstream execute hold.

---
 rtl/id_ex_reg_pkg.sv | 79 +++++++
 rtl/id_ex_reg_if.sv | 74 +++++++
 rtl/id_ex_reg_load_use_detect.sv | 27 ++
 rtl/id_ex_reg.sv | 130 +++++++++++++
 tb/tb_id_ex_reg.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared core definitions used by the ID/EX pipeline register: branch type,
// ALU class and opcode encodings, the x0 register index, and the packed
// control/data records that make up the execute-stage register.
package id_ex_reg_pkg;

  localparam int XLEN = 32;

  // Architectural zero register; never a real write destination.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Branch type carried down the pipe (3 bits).
  localparam logic [2:0] BRANCH_TYPE_NONE    = 3'd0;
  localparam logic [2:0] BRANCH_TYPE_BEQ     = 3'd1;
  localparam logic [2:0] BRANCH_TYPE_BNE     = 3'd2;
  localparam logic [2:0] BRANCH_TYPE_BLT     = 3'd3;
  localparam logic [2:0] BRANCH_TYPE_BGE     = 3'd4;
  localparam logic [2:0] BRANCH_TYPE_BLTU    = 3'd5;
  localparam logic [2:0] BRANCH_TYPE_BGEU    = 3'd6;
  localparam logic [2:0] BRANCH_TYPE_INVALID = 3'd7;

  // ALU operation class handed to the execute-stage ALU decoder (2 bits).
  localparam logic [1:0] ALU_OP_DEFAULT = 2'd0;  // add (loads, stores, address calc)
  localparam logic [1:0] ALU_OP_BRANCH  = 2'd1;  // compare
  localparam logic [1:0] ALU_OP_RTYPE   = 2'd2;  // funct3/funct7 decoded
  localparam logic [1:0] ALU_OP_ITYPE   = 2'd3;  // funct3 decoded, immediate operand

  // Base opcodes (RV32I).
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  // Control half of the execute-stage register.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       result_src;
    logic [2:0] branch;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       funct7b5;
  } ctrl_t;

  // Data half of the execute-stage register.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } data_t;

  // Turn a control record into a bubble: nothing architectural may happen.
  // ALU source and funct fields are left alone; they are don't-care once
  // valid is low.
  function automatic ctrl_t bubble_ctrl(input ctrl_t c);
    ctrl_t b;
    b            = c;
    b.valid      = 1'b0;
    b.reg_write  = 1'b0;
    b.mem_write  = 1'b0;
    b.mem_read   = 1'b0;
    b.result_src = 1'b0;
    b.branch     = BRANCH_TYPE_INVALID;
    b.alu_op     = ALU_OP_DEFAULT;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode/execute boundary bundle: decode-stage (D) fields entering the
// register, execute-stage (E) copies leaving it, and the hazard/stall
// side-band. The decode side drives through 'master', the register
// itself connects through 'slave'.
interface id_ex_reg_if #(
  parameter int XLEN = id_ex_reg_pkg::XLEN
);

  // Decode-stage inputs
  logic            RegWriteD;
  logic            MemWriteD;
  logic            MemReadD;
  logic            ALUSrcD;
  logic            ResultSrcD;
  logic [2:0]      BranchD;
  logic [1:0]      ALUOpD;
  logic            ValidD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] ImmExtD;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      RdD;
  logic [2:0]      funct3D;
  logic            funct7b5D;

  // Pipeline control from execute
  logic            FlushE;
  logic            StallE;

  // Execute-stage outputs
  logic            RegWriteE;
  logic            MemWriteE;
  logic            MemReadE;
  logic            ALUSrcE;
  logic            ResultSrcE;
  logic [2:0]      BranchE;
  logic [1:0]      ALUOpE;
  logic            ValidE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic [2:0]      funct3E;
  logic            funct7b5E;

  // Stall requests and bubble statistics
  logic            StallF;
  logic            StallD;
  logic [31:0]     BubbleCnt;

  modport master (
    output RegWriteD, MemWriteD, MemReadD, ALUSrcD, ResultSrcD, BranchD,
           ALUOpD, ValidD, PCD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           funct3D, funct7b5D, FlushE, StallE,
    input  RegWriteE, MemWriteE, MemReadE, ALUSrcE, ResultSrcE, BranchE,
           ALUOpE, ValidE, PCE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE,
           funct3E, funct7b5E, StallF, StallD, BubbleCnt
  );

  modport slave (
    input  RegWriteD, MemWriteD, MemReadD, ALUSrcD, ResultSrcD, BranchD,
           ALUOpD, ValidD, PCD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           funct3D, funct7b5D, FlushE, StallE,
    output RegWriteE, MemWriteE, MemReadE, ALUSrcE, ResultSrcE, BranchE,
           ALUOpE, ValidE, PCE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE,
           funct3E, funct7b5E, StallF, StallD, BubbleCnt
  );

endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the
// destination of a load currently sitting in execute. Rs2 is always
// compared, even for formats without rs2; a spurious stall only costs a
// cycle, a missed one corrupts data. x0 never creates a dependency.
module load_use_detect
  import id_ex_reg_pkg::*;
(
  input  logic       valid_e,
  input  logic       mem_read_e,
  input  logic [4:0] rd_e,
  input  logic       valid_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  output logic       hazard_d
);

  logic load_in_e_s;
  logic rd_match_s;

  // Decide whether the decode operands depend on an in-flight load
  always_comb begin
    load_in_e_s = valid_e & mem_read_e & (rd_e != REG_X0);
    rd_match_s  = (rd_e == rs1_d) | (rd_e == rs2_d);
    hazard_d    = load_in_e_s & valid_d & rd_match_s;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the 5-stage core.
// Captures decoder controls and decode-stage operands for execute, inserts
// a bubble on a load-use hazard (while stalling fetch/decode), honours a
// branch flush from execute and holds while execute is busy.
// Update priority per edge: FlushE, then StallE, then load-use, then load.
// Build option: define IDEX_BUBBLE_CNT_EN to get a free-running count of
// bubbles written into E on BubbleCnt; otherwise BubbleCnt reads 0.
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  id_ex_reg_if.slave bus
);

  ctrl_t ctrl_r;
  data_t data_r;
  ctrl_t ctrl_d_s;
  data_t data_d_s;
  ctrl_t ctrl_next_s;
  data_t data_next_s;
  logic  hazard_s;

  // Assemble the decode-stage fields into register records
  always_comb begin
    ctrl_d_s            = '0;
    data_d_s            = '0;
    ctrl_d_s.valid      = bus.ValidD;
    ctrl_d_s.reg_write  = bus.RegWriteD;
    ctrl_d_s.mem_write  = bus.MemWriteD;
    ctrl_d_s.mem_read   = bus.MemReadD;
    ctrl_d_s.alu_src    = bus.ALUSrcD;
    ctrl_d_s.result_src = bus.ResultSrcD;
    ctrl_d_s.branch     = bus.BranchD;
    ctrl_d_s.alu_op     = bus.ALUOpD;
    ctrl_d_s.funct3     = bus.funct3D;
    ctrl_d_s.funct7b5   = bus.funct7b5D;
    data_d_s.pc         = bus.PCD;
    data_d_s.rd1        = bus.RD1D;
    data_d_s.rd2        = bus.RD2D;
    data_d_s.imm_ext    = bus.ImmExtD;
    data_d_s.rs1        = bus.Rs1D;
    data_d_s.rs2        = bus.Rs2D;
    data_d_s.rd         = bus.RdD;
  end

  load_use_detect u_load_use_detect (
    .valid_e    (ctrl_r.valid),
    .mem_read_e (ctrl_r.mem_read),
    .rd_e       (data_r.rd),
    .valid_d    (bus.ValidD),
    .rs1_d      (bus.Rs1D),
    .rs2_d      (bus.Rs2D),
    .hazard_d   (hazard_s)
  );

  // Stall requests are purely combinational so the hazard costs no extra cycle
  assign bus.StallF = hazard_s | bus.StallE;
  assign bus.StallD = hazard_s | bus.StallE;

  // Select what E holds after the next edge; flush beats every other request
  always_comb begin
    ctrl_next_s = ctrl_r;
    data_next_s = data_r;
    if (bus.FlushE) begin
      ctrl_next_s = bubble_ctrl(ctrl_r);
    end else if (bus.StallE) begin
      ctrl_next_s = ctrl_r;
    end else if (hazard_s) begin
      ctrl_next_s = bubble_ctrl(ctrl_r);
    end else begin
      ctrl_next_s = ctrl_d_s;
      data_next_s = data_d_s;
    end
  end

  // Execute-stage register; reset leaves a bubble with cleared data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= bubble_ctrl(ctrl_t'('0));
      data_r <= '0;
    end else begin
      ctrl_r <= ctrl_next_s;
      data_r <= data_next_s;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  logic        bubble_wr_s;
  logic [31:0] bubble_cnt_r;

  // A bubble is written on flush, or on load-use when execute is not holding
  assign bubble_wr_s = bus.FlushE | (~bus.StallE & hazard_s);

  // Count bubbles written into E; wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_r <= 32'd0;
    end else if (bubble_wr_s) begin
      bubble_cnt_r <= bubble_cnt_r + 32'd1;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign bus.BubbleCnt = bubble_cnt_r;
`else
  assign bus.BubbleCnt = 32'd0;
`endif

  // Drive the execute-stage outputs straight from the register
  assign bus.ValidE     = ctrl_r.valid;
  assign bus.RegWriteE  = ctrl_r.reg_write;
  assign bus.MemWriteE  = ctrl_r.mem_write;
  assign bus.MemReadE   = ctrl_r.mem_read;
  assign bus.ALUSrcE    = ctrl_r.alu_src;
  assign bus.ResultSrcE = ctrl_r.result_src;
  assign bus.BranchE    = ctrl_r.branch;
  assign bus.ALUOpE     = ctrl_r.alu_op;
  assign bus.funct3E    = ctrl_r.funct3;
  assign bus.funct7b5E  = ctrl_r.funct7b5;
  assign bus.PCE        = data_r.pc;
  assign bus.RD1E       = data_r.rd1;
  assign bus.RD2E       = data_r.rd2;
  assign bus.ImmExtE    = data_r.imm_ext;
  assign bus.Rs1E       = data_r.rs1;
  assign bus.Rs2E       = data_r.rs2;
  assign bus.RdE        = data_r.rd;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a table of decode-stage vectors, each
// naming the expected stall request and which earlier row's fields E must
// hold afterwards (optionally as a bubble), plus a hand-written async reset
// sequence during a load-use stall.
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  logic clk;
  logic rst_n;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         flush;
    bit         stall_e;
    bit         valid;
    bit         regw;
    bit         memr;
    bit         memw;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] br;
    logic [1:0] aluop;
    bit         exp_stall;
    int         src;
    bit         bub;
    bit         inc;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic        regw;
    logic        memw;
    logic        memr;
    logic        alusrc;
    logic        resultsrc;
    logic [2:0]  br;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } e_t;

  localparam int NV = 25;
  vec_t tbl [NV];
  e_t   sb_q [$];
  int   checks;
  int   failures;
  int   exp_cnt;

  function automatic vec_t mk(bit flush, bit stall_e, bit valid, bit regw, bit memr, bit memw,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic [2:0] br, logic [1:0] aluop,
                              bit exp_stall, int src, bit bub, bit inc);
    vec_t v;
    v.flush = flush; v.stall_e = stall_e; v.valid = valid; v.regw = regw;
    v.memr = memr; v.memw = memw; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.br = br; v.aluop = aluop; v.exp_stall = exp_stall; v.src = src;
    v.bub = bub; v.inc = inc;
    return v;
  endfunction

  // Per-row data payload, distinct for every row index.
  function automatic logic [31:0] pc_of(int idx);  return 32'h0000_1000 + 32'(idx) * 32'd4; endfunction
  function automatic logic [31:0] rd1_of(int idx); return 32'hD100_0000 | 32'(idx); endfunction
  function automatic logic [31:0] rd2_of(int idx); return 32'hD200_0000 | 32'(idx); endfunction
  function automatic logic [31:0] imm_of(int idx); return 32'h1110_0000 | 32'(idx); endfunction

  function automatic e_t build_e(bit valid, bit regw, bit memr, bit memw,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                 logic [2:0] br, logic [1:0] aluop, int idx);
    e_t e;
    logic [31:0] ii;
    ii = 32'(idx);
    e.valid = valid; e.regw = regw; e.memw = memw; e.memr = memr;
    e.alusrc = ii[1]; e.resultsrc = memr; e.br = br; e.aluop = aluop;
    e.f3 = ii[2:0]; e.f7 = ii[0];
    e.pc = pc_of(idx); e.rd1 = rd1_of(idx); e.rd2 = rd2_of(idx); e.imm = imm_of(idx);
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    return e;
  endfunction

  function automatic e_t expect_of(int src, bit bub);
    e_t e;
    e = build_e(tbl[src].valid, tbl[src].regw, tbl[src].memr, tbl[src].memw,
                tbl[src].rs1, tbl[src].rs2, tbl[src].rd, tbl[src].br, tbl[src].aluop, src);
    if (bub) begin
      e.valid = 1'b0; e.regw = 1'b0; e.memw = 1'b0; e.memr = 1'b0;
      e.resultsrc = 1'b0; e.br = BRANCH_TYPE_INVALID; e.aluop = ALU_OP_DEFAULT;
    end
    return e;
  endfunction

  function automatic e_t reset_e();
    e_t e;
    e = '0;
    e.br = BRANCH_TYPE_INVALID;
    e.aluop = ALU_OP_DEFAULT;
    return e;
  endfunction

  function automatic e_t sample();
    e_t e;
    e.valid = bus.ValidE; e.regw = bus.RegWriteE; e.memw = bus.MemWriteE; e.memr = bus.MemReadE;
    e.alusrc = bus.ALUSrcE; e.resultsrc = bus.ResultSrcE; e.br = bus.BranchE; e.aluop = bus.ALUOpE;
    e.f3 = bus.funct3E; e.f7 = bus.funct7b5E;
    e.pc = bus.PCE; e.rd1 = bus.RD1E; e.rd2 = bus.RD2E; e.imm = bus.ImmExtE;
    e.rs1 = bus.Rs1E; e.rs2 = bus.Rs2E; e.rd = bus.RdE;
    return e;
  endfunction

  task automatic check(string name, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_fields(bit flush, bit stall_e, bit valid, bit regw, bit memr, bit memw,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic [2:0] br, logic [1:0] aluop, int idx);
    logic [31:0] ii;
    ii = 32'(idx);
    bus.FlushE = flush; bus.StallE = stall_e;
    bus.ValidD = valid; bus.RegWriteD = regw; bus.MemReadD = memr; bus.MemWriteD = memw;
    bus.ALUSrcD = ii[1]; bus.ResultSrcD = memr; bus.BranchD = br; bus.ALUOpD = aluop;
    bus.funct3D = ii[2:0]; bus.funct7b5D = ii[0];
    bus.PCD = pc_of(idx); bus.RD1D = rd1_of(idx); bus.RD2D = rd2_of(idx); bus.ImmExtD = imm_of(idx);
    bus.Rs1D = rs1; bus.Rs2D = rs2; bus.RdD = rd;
  endtask

  task automatic check_cnt(string name);
`ifdef IDEX_BUBBLE_CNT_EN
    check(name, 192'(bus.BubbleCnt), 192'(32'(exp_cnt)));
`else
    check(name, 192'(bus.BubbleCnt), 192'(32'd0));
`endif
  endtask

  initial begin
    e_t got;
    e_t exp;
    logic [2:0] BN, BQ;
    logic [1:0] AD, AR, AI, AB;
    BN = BRANCH_TYPE_NONE; BQ = BRANCH_TYPE_BEQ;
    AD = ALU_OP_DEFAULT; AR = ALU_OP_RTYPE; AI = ALU_OP_ITYPE; AB = ALU_OP_BRANCH;
    checks = 0; failures = 0; exp_cnt = 0;

    //            fl st v  rw mr mw rs1 rs2 rd  br  aluop stall src bub inc
    tbl[0]  = mk(0, 0, 1, 1, 0, 0,  1,  2,  5, BN, AR,   0,  0, 0, 0); // ADD x5
    tbl[1]  = mk(0, 0, 1, 1, 1, 0,  2,  0,  6, BN, AD,   0,  1, 0, 0); // LW x6
    tbl[2]  = mk(0, 0, 1, 1, 0, 0,  6,  3,  7, BN, AR,   1,  1, 1, 1); // load-use rs1
    tbl[3]  = mk(0, 0, 1, 1, 0, 0,  6,  3,  7, BN, AR,   0,  3, 0, 0); // held ADD enters
    tbl[4]  = mk(0, 0, 1, 1, 1, 0,  3,  0,  0, BN, AD,   0,  4, 0, 0); // LW x0
    tbl[5]  = mk(0, 0, 1, 1, 0, 0,  0,  0,  8, BN, AR,   0,  5, 0, 0); // x0 no hazard
    tbl[6]  = mk(0, 0, 1, 1, 1, 0,  4,  5,  9, BN, AD,   0,  6, 0, 0); // LW x9
    tbl[7]  = mk(0, 0, 1, 1, 0, 0,  1,  9, 10, BN, AI,   1,  6, 1, 1); // rs2 match
    tbl[8]  = mk(0, 0, 1, 1, 0, 0,  1,  9, 10, BN, AI,   0,  8, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 1, 0,  2,  0, 11, BN, AD,   0,  9, 0, 0); // LW x11
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 11, 11,  0, BN, AD,   0, 10, 0, 0); // ValidD=0
    tbl[11] = mk(0, 0, 1, 1, 1, 0,  1,  0, 12, BN, AD,   0, 11, 0, 0); // LW x12
    tbl[12] = mk(0, 1, 1, 1, 0, 0, 12,  1, 13, BN, AR,   1, 11, 0, 0); // StallE hold
    tbl[13] = mk(0, 1, 1, 1, 0, 0, 12,  2, 14, BN, AR,   1, 11, 0, 0);
    tbl[14] = mk(0, 1, 1, 1, 0, 0, 12,  3, 15, BN, AR,   1, 11, 0, 0);
    tbl[15] = mk(0, 0, 1, 1, 0, 0, 12,  3, 13, BN, AR,   1, 11, 1, 1); // then load-use
    tbl[16] = mk(0, 0, 1, 1, 0, 0, 12,  3, 13, BN, AR,   0, 16, 0, 0);
    tbl[17] = mk(1, 0, 1, 1, 1, 0,  1,  0, 14, BN, AD,   0, 16, 1, 1); // flush
    tbl[18] = mk(0, 0, 1, 1, 1, 0,  1,  0, 15, BN, AD,   0, 18, 0, 0); // LW x15
    tbl[19] = mk(1, 1, 1, 0, 0, 1, 15, 16,  0, BN, AD,   1, 18, 1, 1); // flush+stall+hazard
    tbl[20] = mk(0, 0, 1, 0, 0, 1, 15, 16,  0, BN, AD,   0, 20, 0, 0); // store
    tbl[21] = mk(1, 0, 1, 1, 0, 0,  1,  2, 17, BN, AR,   0, 20, 1, 1); // flush store
    tbl[22] = mk(0, 0, 1, 0, 0, 0, 17, 18,  0, BQ, AB,   0, 22, 0, 0); // BEQ
    tbl[23] = mk(0, 1, 1, 1, 0, 0,  1,  2, 19, BN, AR,   1, 22, 0, 0); // StallE only
    tbl[24] = mk(0, 0, 1, 1, 0, 0,  1,  2, 19, BN, AR,   0, 24, 0, 0);

    rst_n = 1'b0;
    drive_fields(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, BN, AD, 0);
    @(negedge clk);
    @(negedge clk);
    check("reset_e", 192'(sample()), 192'(reset_e()));
    check("reset_stall", 192'({bus.StallF, bus.StallD}), 192'(2'b00));
    check_cnt("reset_cnt");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_fields(tbl[i].flush, tbl[i].stall_e, tbl[i].valid, tbl[i].regw, tbl[i].memr,
                   tbl[i].memw, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].br, tbl[i].aluop, i);
      #1;
      check($sformatf("row%0d_stall", i), 192'({bus.StallF, bus.StallD}),
            192'({tbl[i].exp_stall, tbl[i].exp_stall}));
      sb_q.push_back(expect_of(tbl[i].src, tbl[i].bub));
      if (tbl[i].inc) exp_cnt++;
      @(posedge clk);
      #1;
      got = sample();
      exp = sb_q.pop_front();
      check($sformatf("row%0d_e", i), 192'(got), 192'(exp));
      check_cnt($sformatf("row%0d_cnt", i));
    end

    // Async reset in the middle of a load-use stall.
    @(negedge clk);
    drive_fields(0, 0, 1, 1, 1, 0, 5'd1, 5'd0, 5'd5, BN, AD, 30);  // LW x5
    @(posedge clk);
    #1;
    check("rst_seq_lw", 192'({bus.ValidE, bus.MemReadE, bus.RdE}), 192'({1'b1, 1'b1, 5'd5}));
    @(negedge clk);
    drive_fields(0, 0, 1, 1, 0, 0, 5'd5, 5'd2, 5'd7, BN, AR, 31);  // ADD x7, x5
    #1;
    check("rst_seq_stall", 192'({bus.StallF, bus.StallD}), 192'(2'b11));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_seq_e", 192'(sample()), 192'(reset_e()));
    check("rst_seq_release", 192'({bus.StallF, bus.StallD}), 192'(2'b00));
    exp_cnt = 0;
    check_cnt("rst_seq_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_seq_nostall", 192'({bus.StallF, bus.StallD}), 192'(2'b00));
    @(posedge clk);
    #1;
    check("rst_seq_add", 192'({bus.ValidE, bus.RdE, bus.RD1E}), 192'({1'b1, 5'd7, rd1_of(31)}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
